// File: rtl/rsa_pkg.sv
// rsa_pkg: shared constants and FSM state type for the Montgomery multiplier.
//
// The operand width is 4096 bits, and each operand is split into sixty-four
// 64-bit words. The accumulator carries 66 extra bits of headroom above the
// key width.
//
// The SUB state exists only when MONT_FINAL_SUB_EN is defined.
package rsa_pkg;

  localparam int KEY_W     = 4096;
  localparam int WORD_W    = 64;
  localparam int NUM_WORDS = 64;
  localparam int T_W       = 4162;
  localparam int IDX_W     = 6;

`ifdef MONT_FINAL_SUB_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RED  = 2'd2,
    SUB  = 2'd3
  } mont_state_e;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RED  = 2'd2
  } mont_state_e;
`endif

endpackage

// File: rtl/mont_word_mac.sv
// mont_word_mac: combinational multiply-accumulate, sum_o = acc_i + x_i * y_i.
//
// It is shared by the MUL step (x = word of a, y = b) and the RED step
// (x = m, y = n). The sum is always less than 2^4162, so no bits are lost.
//
// Ports:
//   acc_i  [T_W-1:0]     running accumulator T
//   x_i    [WORD_W-1:0]  64-bit multiplier word
//   y_i    [KEY_W-1:0]   4096-bit multiplicand
//   sum_o  [T_W-1:0]     acc_i + x_i * y_i
module mont_word_mac
  import rsa_pkg::*;
(
  input  logic [T_W-1:0]    acc_i,
  input  logic [WORD_W-1:0] x_i,
  input  logic [KEY_W-1:0]  y_i,
  output logic [T_W-1:0]    sum_o
);

  logic [T_W-1:0] xWide;
  logic [T_W-1:0] yWide;

  // Widen both factors to the accumulator width so that the product is
  // formed at full precision.
  assign xWide = {{(T_W-WORD_W){1'b0}}, x_i};
  assign yWide = {{(T_W-KEY_W){1'b0}}, y_i};
  assign sum_o = acc_i + xWide * yWide;

endmodule

// File: rtl/mont_mul.sv
// mont_mul: word-serial CIOS Montgomery multiplier.
// It computes result = a*b*2^-4096 mod n using one 64-bit word of a per
// MUL/RED pair.
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   go              start request (accepted only in IDLE)
//   a, b, n         4096-bit operands and odd modulus (registered on accept)
//   n_prime         -n^-1 mod 2^64
//   n_prime_valid   qualifies n_prime; go without it pulses err
//   result          product, held until the next valid pulse
//   valid           one-cycle pulse when result updates
//   busy            high while an operation is in flight
//   err             one-cycle pulse when go is rejected
//
// Build option MONT_FINAL_SUB_EN:
//   Defined: a SUB state performs the final conditional subtraction.
//            Latency is 129 cycles and the result lies in [0,n).
//   Undefined: the last RED writes the result directly. Latency is
//            128 cycles and the result lies in [0,2n).
module mont_mul
  import rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic [KEY_W-1:0]  a,
  input  logic [KEY_W-1:0]  b,
  input  logic [KEY_W-1:0]  n,
  input  logic [WORD_W-1:0] n_prime,
  input  logic              n_prime_valid,
  output logic [KEY_W-1:0]  result,
  output logic              valid,
  output logic              busy,
  output logic              err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  mont_state_e       state_q,  state_d;
  logic [KEY_W-1:0]  aReg_q,   aReg_d;
  logic [KEY_W-1:0]  bReg_q,   bReg_d;
  logic [KEY_W-1:0]  nReg_q,   nReg_d;
  logic [WORD_W-1:0] nPrime_q, nPrime_d;
  logic [T_W-1:0]    accT_q,   accT_d;
  logic [IDX_W-1:0]  idx_q,    idx_d;
  logic [KEY_W-1:0]  result_q, result_d;
  logic              valid_q,  valid_d;
  logic              err_q,    err_d;

  logic [WORD_W-1:0]      aWord;
  logic [WORD_W-1:0]      redM;
  logic [WORD_W-1:0]      macX;
  logic [KEY_W-1:0]       macY;
  logic [T_W-1:0]         macSum;
  logic [T_W-WORD_W-1:0]  redT;
  logic [KEY_W-1:0]       finalRes;

  // Word i of the registered a operand, and the reduction factor
  // m = T[63:0] * n' mod 2^64.
  assign aWord = aReg_q[{idx_q, 6'd0} +: WORD_W];
  assign redM  = accT_q[WORD_W-1:0] * nPrime_q;

  // The single MAC is steered to a_i*b in MUL and to m*n in RED.
  assign macX = (state_q == RED) ? redM   : aWord;
  assign macY = (state_q == RED) ? nReg_q : bReg_q;

  mont_word_mac u_mac (
    .acc_i (accT_q),
    .x_i   (macX),
    .y_i   (macY),
    .sum_o (macSum)
  );

  // After adding m*n the low word is zero, so the shift is exact.
  assign redT = macSum[T_W-1:WORD_W];

`ifdef MONT_FINAL_SUB_EN
  logic [KEY_W-1:0] subDiff;

  // T < 2n here, so T-n fits in 4096 bits whenever it is selected.
  assign subDiff  = accT_q[KEY_W-1:0] - nReg_q;
  assign finalRes = (accT_q >= {{(T_W-KEY_W){1'b0}}, nReg_q}) ? subDiff
                                                               : accT_q[KEY_W-1:0];
`else
  logic [KEY_W-1:0] foldDiff;

  // An almost-reduced value can reach 2^4096 when n is close to 2^4096.
  // A value that large cannot fit on the port, so one n is removed.
  // The remainder stays in [0,2n) and keeps the same residue.
  assign foldDiff = redT[KEY_W-1:0] - nReg_q;
  assign finalRes = redT[KEY_W] ? foldDiff : redT[KEY_W-1:0];
`endif

  // Next-state logic. Every register holds its value by default, while
  // valid and err default low so that each one is a single-cycle pulse.
  always_comb begin
    state_d  = state_q;
    aReg_d   = aReg_q;
    bReg_d   = bReg_q;
    nReg_d   = nReg_q;
    nPrime_d = nPrime_q;
    accT_d   = accT_q;
    idx_d    = idx_q;
    result_d = result_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          if (n_prime_valid) begin
            aReg_d   = a;
            bReg_d   = b;
            nReg_d   = n;
            nPrime_d = n_prime;
            accT_d   = '0;
            idx_d    = '0;
            state_d  = MUL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      MUL: begin
        accT_d  = macSum;
        state_d = RED;
      end
      RED: begin
        accT_d = {{WORD_W{1'b0}}, redT};
        if (idx_q != LAST_IDX) begin
          idx_d   = idx_q + 1'b1;
          state_d = MUL;
        end else begin
`ifdef MONT_FINAL_SUB_EN
          state_d = SUB;
`else
          result_d = finalRes;
          valid_d  = 1'b1;
          state_d  = IDLE;
`endif
        end
      end
`ifdef MONT_FINAL_SUB_EN
      SUB: begin
        result_d = finalRes;
        valid_d  = 1'b1;
        state_d  = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State registers. Reset aborts any operation in flight, so an aborted
  // operation never raises valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      aReg_q   <= '0;
      bReg_q   <= '0;
      nReg_q   <= '0;
      nPrime_q <= '0;
      accT_q   <= '0;
      idx_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      aReg_q   <= aReg_d;
      bReg_q   <= bReg_d;
      nReg_q   <= nReg_d;
      nPrime_q <= nPrime_d;
      accT_q   <= accT_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

  assign result = result_q;
  assign valid  = valid_q;
  assign err    = err_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: doc/mont_mul.md
MONT_MUL -- requirements
Module: mont_mul

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-002 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port go  in  1  start request, sampled on each clk edge.
REQ-004 SHALL have ports a, b  in  4096 each  multiplicands, both < n.
REQ-005 SHALL have port n  in  4096  odd RSA modulus.
REQ-006 SHALL have port n_prime  in  64  -n^-1 mod 2^64, as produced by the team's modular-inverse block.
REQ-007 SHALL have port n_prime_valid  in  1  qualifies n_prime; driven by that block's valid output.
REQ-008 SHALL have port result  out  4096  a*b*2^-4096 mod n.
REQ-009 SHALL have port valid  out  1  one-cycle pulse when result updates.
REQ-010 SHALL have port busy  out  1  high while an operation is in flight.
REQ-011 SHALL have port err  out  1  one-cycle pulse when go is rejected.

Function
REQ-012 SHALL implement word-serial CIOS Montgomery multiplication with R=2^4096, 64-bit words, 64 iterations.
REQ-013 SHALL use FSM states IDLE, MUL, RED, SUB.
REQ-014 In IDLE with go=1 and n_prime_valid=1: SHALL register a, b, n and n_prime, clear accumulator T and word index i, and enter MUL.
REQ-015 In IDLE with go=1 and n_prime_valid=0: SHALL pulse err for one cycle, stay in IDLE, and leave result unchanged.
REQ-016 In MUL: SHALL set T <= T + a[64i+63:64i]*b, then enter RED.
REQ-017 In RED: SHALL compute m = (T[63:0]*n_prime) mod 2^64 and set T <= (T+m*n)>>64. Next state: MUL if i<63 (i incremented), else SUB.
REQ-018 T SHALL be 4162 bits wide; no intermediate truncation other than the exact >>64.
REQ-019 In SUB: SHALL set result <= (T>=n) ? T-n : T (4096 bits), pulse valid, and return to IDLE.
REQ-020 Latency: valid SHALL be registered on the 129th clk edge after the edge at which go is accepted.
REQ-021 busy SHALL be high from the edge after acceptance through the edge that asserts valid.
REQ-022 go while busy SHALL be ignored: no err, no restart.
REQ-023 Input changes while busy SHALL have no effect on the operation; only the registered copies are used.
REQ-024 result SHALL hold its value until the next valid pulse.
REQ-025 Back-to-back operation: go in the cycle valid is high SHALL be accepted.

Reset
REQ-026 rst_n=0 at a clk edge SHALL force IDLE and clear result, valid, busy, err, T and i to 0, including mid-operation; the aborted operation SHALL never produce valid.
REQ-027 The first go after reset release SHALL behave as REQ-014/015.

Configuration
REQ-028 Macro MONT_FINAL_SUB_EN defined: SUB state present per REQ-019, latency 129, result in [0,n).
REQ-029 Macro MONT_FINAL_SUB_EN undefined: no SUB state. The final RED SHALL write result <= T[4095:0] and pulse valid, giving latency 128 and result in [0,2n) (almost-Montgomery form, congruent to a*b*R^-1 mod n). Inputs SHALL then be allowed < 2n.

Structure
REQ-030 Package rsa_pkg SHALL hold KEY_W=4096, WORD_W=64, NUM_WORDS=64, T_W=4162 and the FSM state typedef.
REQ-031 One sub-module, mont_word_mac (combinational acc + 64-bit x 4096-bit product), SHALL be instantiated and shared by MUL and RED.

Verification
REQ-032 n=2^4096-1, n_prime=1, a=2, b=3, go -> valid at +129 edges, result=6.
REQ-033 n=3, n_prime=0x5555555555555555, a=2, b=2 -> result=1; repeat with a=0, b=2 -> result=0.
REQ-034 n=2^4096-1, n_prime=1, a=b=n-1 -> result=1 (with MONT_FINAL_SUB_EN); without the macro, result mod n = 1 and valid at +128 edges.
REQ-035 go with n_prime_valid=0 -> err high exactly one cycle, busy=0, valid never asserts, result unchanged.
REQ-036 Accept go, second go at +10 edges -> exactly one valid pulse at +129 edges; rst_n=0 at +50 edges in a separate run -> busy, valid, result all 0, no valid pulse; the next go after release completes normally.
